// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: opcodes, FSM state encoding and SPI address width shared by
// the SPI serial RAM responder and the Wishbone SPI memory initiator.
package spi_sram_pkg;

    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FREAD = 8'h0B;

    localparam int ADDR_BITS_SPI = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchronizer for one asynchronous SPI pin, plus
// single-clk rise/fall pulses derived from the synced value and its delay.
// Ports:
//   clk, rst  system clock, async active-high reset
//   d         raw asynchronous input
//   q         synchronized level
//   rise      one-clk pulse on a synced 0->1
//   fall      one-clk pulse on a synced 1->0
// RST_VAL sets the idle level the flops reset to, so that releasing reset
// with the pin at its idle level produces no spurious edge.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= RST_VAL;
            s2  <= RST_VAL;
            dly <= RST_VAL;
        end else begin
            s1  <= d;
            s2  <= s1;
            dly <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~dly;
    assign fall = ~s2 & dly;

endmodule

// File: rtl/spi_sram_resp.sv
// spi_sram_resp: SPI-slave serial RAM responder backed by an on-chip byte
// array of 2**ADDR_W bytes. Commands: 0x66 reset-enable, 0x99 reset,
// 0x02 write, 0x03 read, 24-bit address, data MSB-first. All SPI pins are
// oversampled on clk; MOSI is taken on SCK rise, MISO changes on SCK fall.
// Optional feature macro: SPI_SRAM_FAST_READ_EN accepts 0x0B (fast read,
// 8 dummy SCK cycles after the address); when undefined 0x0B is unknown.
// Ports:
//   clk, rst     system clock, async active-high reset
//   spi_clk_i    SCK (idle low)
//   spi_cs_i     chip select, active low
//   spi_data_i   MOSI
//   spi_data_o   MISO (0 whenever spi_oe_o is 0)
//   spi_oe_o     MISO output enable
//   rst_done_o   sticky, set by 0x66 followed by 0x99
//   cmd_err_o    one-clk pulse on an unknown opcode
module spi_sram_resp
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int CLK_RATIO_MIN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk_i,
    input  logic spi_cs_i,
    input  logic spi_data_i,
    output logic spi_data_o,
    output logic spi_oe_o,
    output logic rst_done_o,
    output logic cmd_err_o
);

    // CLK_RATIO_MIN documents the oversampling requirement; the edge
    // detector cannot resolve SCK phases shorter than a few clk.
    if (CLK_RATIO_MIN < 4) begin : g_ratio_chk
        $error("spi_sram_resp: CLK_RATIO_MIN below 4 cannot be oversampled");
    end

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(spi_clk_i),
        .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs_i),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_data_i),
        .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sck_s, cs_rise, mosi_rise, mosi_fall};

    state_t            state;
    logic [4:0]        cnt;       // rises remaining in the current field
    logic [3:0]        dcnt;      // dummy rises remaining before read data
    logic [6:0]        sr;        // MOSI byte being assembled
    logic [7:0]        op;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        out_sr;
    logic              load;      // next fall starts a fresh byte from rd_data
    logic              rst_en;

    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        rd_data;

    logic [7:0]        shift_in;
    logic [ADDR_W-1:0] ptr_in;
    logic              we;

    assign shift_in = {sr, mosi_s};
    // Shifting all 24 address bits through the pointer keeps only the low
    // ADDR_W bits, which is exactly the wanted truncation.
    assign ptr_in   = {ptr[ADDR_W-2:0], mosi_s};
    assign we       = (state == ST_WRITE) && !cs_s && sck_rise && (cnt == 5'd0);

    // rd_data follows mem[ptr] one clk behind, so a fetch is in place long
    // before the next SCK fall at any legal clock ratio.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr] <= shift_in;
        end
        rd_data <= mem[ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dcnt       <= '0;
            sr         <= '0;
            op         <= '0;
            ptr        <= '0;
            out_sr     <= '0;
            load       <= 1'b0;
            rst_en     <= 1'b0;
            spi_data_o <= 1'b0;
            spi_oe_o   <= 1'b0;
            rst_done_o <= 1'b0;
            cmd_err_o  <= 1'b0;
        end else begin
            cmd_err_o <= 1'b0;
            if (cs_s) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                dcnt       <= '0;
                load       <= 1'b0;
                spi_oe_o   <= 1'b0;
                spi_data_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state <= ST_CMD;
                            cnt   <= 5'd7;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            sr <= shift_in[6:0];
                            if (cnt == 5'd0) begin
                                op <= shift_in;
                                case (shift_in)
                                    CMD_WRITE, CMD_READ: begin
                                        state  <= ST_ADDR;
                                        cnt    <= 5'(ADDR_BITS_SPI - 1);
                                        rst_en <= 1'b0;
                                    end
`ifdef SPI_SRAM_FAST_READ_EN
                                    CMD_FREAD: begin
                                        state  <= ST_ADDR;
                                        cnt    <= 5'(ADDR_BITS_SPI - 1);
                                        rst_en <= 1'b0;
                                    end
`endif
                                    CMD_RSTEN: begin
                                        state  <= ST_IGNORE;
                                        rst_en <= 1'b1;
                                    end
                                    CMD_RST: begin
                                        state  <= ST_IGNORE;
                                        rst_en <= 1'b0;
                                        if (rst_en) begin
                                            rst_done_o <= 1'b1;
                                        end
                                    end
                                    default: begin
                                        state     <= ST_IGNORE;
                                        rst_en    <= 1'b0;
                                        cmd_err_o <= 1'b1;
                                    end
                                endcase
                            end else begin
                                cnt <= cnt - 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            ptr <= ptr_in;
                            if (cnt == 5'd0) begin
                                cnt <= 5'd7;
                                if (op == CMD_WRITE) begin
                                    state <= ST_WRITE;
                                end else begin
                                    state <= ST_READ;
                                    load  <= 1'b1;
                                    dcnt  <= (op == CMD_FREAD) ? 4'd8 : 4'd0;
                                end
                            end else begin
                                cnt <= cnt - 5'd1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (sck_rise) begin
                            sr <= shift_in[6:0];
                            if (cnt == 5'd0) begin
                                ptr <= ptr + 1'b1;
                                cnt <= 5'd7;
                            end else begin
                                cnt <= cnt - 5'd1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (sck_rise) begin
                            if (dcnt != 4'd0) begin
                                dcnt <= dcnt - 4'd1;
                            end else if (cnt == 5'd0) begin
                                // Advance on the 8th rise so rd_data holds
                                // the next byte before the fall that needs it.
                                ptr  <= ptr + 1'b1;
                                cnt  <= 5'd7;
                                load <= 1'b1;
                            end else begin
                                cnt <= cnt - 5'd1;
                            end
                        end
                        if (sck_fall && (dcnt == 4'd0)) begin
                            spi_oe_o <= 1'b1;
                            if (load) begin
                                spi_data_o <= rd_data[7];
                                out_sr     <= {rd_data[6:0], 1'b0};
                                load       <= 1'b0;
                            end else begin
                                spi_data_o <= out_sr[7];
                                out_sr     <= {out_sr[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;  // ST_IGNORE: wait for CS high
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sram_resp.sv
module tb_spi_sram_resp;

    localparam int H         = 6;      // SCK half period in clk
    localparam int AW        = 10;
    localparam int DEPTH     = 1 << AW;
    localparam int RATIO_MIN = 8;

    logic clk = 1'b0;
    logic rst;
    logic sck, cs, mosi;
    logic miso, oe, rst_done, cmd_err;

    always #5 clk = ~clk;

    spi_sram_resp #(.ADDR_W(AW), .CLK_RATIO_MIN(RATIO_MIN)) dut (
        .clk(clk), .rst(rst),
        .spi_clk_i(sck), .spi_cs_i(cs), .spi_data_i(mosi),
        .spi_data_o(miso), .spi_oe_o(oe),
        .rst_done_o(rst_done), .cmd_err_o(cmd_err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [7:0] wbuf [16];
    logic [7:0] rbuf [16];
    int wa [10];
    int wn [10];

    int err_pulses = 0;
    int oe_cycles  = 0;

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_pulses++;
        if (oe === 1'b1) oe_cycles++;
        if (!rst && oe !== 1'b1 && miso !== 1'b0) begin
            errors++;
            $error("FAIL miso_idle: observed %b required 0 while oe=0", miso);
        end
    end

    int   since_rise = 0;
    bit   seen_rise  = 0;
    logic sck_q      = 1'b0;
    always @(posedge clk) begin
        if (sck === 1'b1 && sck_q === 1'b0) begin
            if (seen_rise) begin
                assert (since_rise >= RATIO_MIN) else begin
                    errors++;
                    $error("FAIL clk_ratio: observed %0d required >= %0d", since_rise, RATIO_MIN);
                end
            end
            seen_rise  = 1;
            since_rise = 1;
        end else begin
            since_rise++;
        end
        sck_q = sck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sck_cycle(input logic b, output logic r);
        mosi = b;
        repeat (H) @(negedge clk);
        r = miso;
        sck = 1'b1;
        repeat (H) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic rb;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck_cycle(tx[7-i], rb);
            rx[7-i] = rb;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic d;
        for (int i = 23; i >= 0; i--) sck_cycle(a[i], d);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic [7:0] d;
        xfer(c, 8, d);
    endtask

    // Writes wbuf[0..n-1] from address a; partial>0 adds that many bits of
    // wbuf[n] before CS rises (an incomplete byte that must be dropped).
    task automatic do_write(input int a, input int n, input int partial);
        logic [7:0] d;
        cs_low();
        send_cmd(8'h02);
        send_addr(24'(a));
        for (int i = 0; i < n; i++) begin
            xfer(wbuf[i], 8, d);
            ref_mem[(a + i) % DEPTH] = wbuf[i];
        end
        if (partial > 0) xfer(wbuf[n], partial, d);
        cs_high();
    endtask

    task automatic do_read(input logic [7:0] op, input int a, input int n);
        logic d;
        logic [7:0] rx;
        cs_low();
        send_cmd(op);
        send_addr(24'(a));
        if (op == 8'h0B) begin
            for (int i = 0; i < 8; i++) sck_cycle(1'($urandom_range(0, 1)), d);
        end
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, rx);
            rbuf[i] = rx;
        end
        cs_high();
    endtask

    task automatic check_read(input string tag, input int a, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(rbuf[i]), 32'(ref_mem[(a + i) % DEPTH]));
    endtask

    initial begin
        int base_err;
        int base_oe;
        logic d;

        rst  = 1'b1;
        cs   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_done_rst", 32'(rst_done), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Lone 0x99 after reset must not set rst_done
        base_err = err_pulses;
        cs_low(); send_cmd(8'h99); cs_high();
        check("lone_rst", 32'(rst_done), 32'd0);
        check("lone_rst_err", 32'(err_pulses - base_err), 32'd0);

        // 0x66, CS pulse, 0x99
        cs_low(); send_cmd(8'h66); cs_high();
        check("rsten_only", 32'(rst_done), 32'd0);
        cs_low(); send_cmd(8'h99);
        check("rst_seq", 32'(rst_done), 32'd1);
        cs_high();

        // Write then read back four bytes at 0x10
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3; wbuf[3] = 8'h3C;
        do_write(32'h10, 4, 0);
        do_read(8'h03, 32'h10, 4);
        check_read("rd10", 32'h10, 4);
        check("rd10_word", {rbuf[3], rbuf[2], rbuf[1], rbuf[0]}, 32'h3CC35AA5);

        // Pointer wrap at the top of the array
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(32'h3FF, 2, 0);
        check("wrap_mem3ff", 32'(dut.mem[10'h3FF]), 32'h11);
        check("wrap_mem000", 32'(dut.mem[10'h000]), 32'h22);
        do_read(8'h03, 32'h3FF, 2);
        check("wrap_rd0", 32'(rbuf[0]), 32'h11);
        check("wrap_rd1", 32'(rbuf[1]), 32'h22);

        // Aborted write: 2nd byte cut after 5 bits
        wbuf[0] = 8'h77; wbuf[1] = 8'h88;
        do_write(32'h20, 2, 0);
        wbuf[0] = 8'h99; wbuf[1] = 8'h55;
        do_write(32'h20, 1, 5);
        do_read(8'h03, 32'h20, 2);
        check("abort_b0", 32'(rbuf[0]), 32'h99);
        check("abort_b1", 32'(rbuf[1]), 32'h88);

        // CS rising mid-read drops oe within 3 clk
        cs_low(); send_cmd(8'h03); send_addr(24'h10);
        begin
            logic [7:0] rx;
            xfer(8'h00, 8, rx);
            check("abort_rd_byte", 32'(rx), 32'hA5);
        end
        check("abort_oe_on", 32'(oe), 32'd1);
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_oe_off", 32'(oe), 32'd0);
        repeat (H) @(negedge clk);

        // Unknown opcode: one error pulse, MISO never enabled
        base_err = err_pulses;
        base_oe  = oe_cycles;
        cs_low(); send_cmd(8'h9F);
        for (int i = 0; i < 32; i++) sck_cycle(1'($urandom_range(0, 1)), d);
        cs_high();
        check("unk_err", 32'(err_pulses - base_err), 32'd1);
        check("unk_oe", 32'(oe_cycles - base_oe), 32'd0);
        do_read(8'h03, 32'h10, 4);
        check_read("unk_rd", 32'h10, 4);

`ifdef SPI_SRAM_FAST_READ_EN
        base_err = err_pulses;
        do_read(8'h0B, 32'h10, 4);
        check_read("fread", 32'h10, 4);
        check("fread_err", 32'(err_pulses - base_err), 32'd0);
`else
        base_err = err_pulses;
        base_oe  = oe_cycles;
        cs_low(); send_cmd(8'h0B);
        for (int i = 0; i < 32; i++) sck_cycle(1'b0, d);
        cs_high();
        check("fread_unk_err", 32'(err_pulses - base_err), 32'd1);
        check("fread_unk_oe", 32'(oe_cycles - base_oe), 32'd0);
`endif

        // Randomized writes and reads against the byte-array model
        for (int k = 0; k < 10; k++) begin
            wa[k] = int'($urandom_range(0, DEPTH - 1));
            wn[k] = int'($urandom_range(1, 6));
            for (int i = 0; i < wn[k]; i++) wbuf[i] = 8'($urandom);
            do_write(wa[k], wn[k], 0);
        end
        for (int k = 0; k < 10; k++) begin
            int j;
            int len;
            j   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, wn[j]));
            do_read(8'h03, wa[j], len);
            check_read($sformatf("rnd%0d", k), wa[j], len);
        end

        // Async reset mid-write: outputs return to reset, array kept
        cs_low(); send_cmd(8'h02); send_addr(24'h300);
        begin
            logic [7:0] rx;
            xfer(8'hFF, 4, rx);
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_done", 32'(rst_done), 32'd0);
        check("midrst_oe", 32'(oe), 32'd0);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_read(8'h03, 32'h10, 4);
        check_read("postrst_rd", 32'h10, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL timeout: observed no finish, required finish before 5ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
